fx2f_norm_round: RTL
====================

Name: fx2f_norm_round

Overview:
- Parametrised fixed-point to float converter for the FLOG datapath; successor to the bfloat16-only integer/log-fraction converter.
- Converts a signed fixed-point value {int_i, frac_i} into sign/exponent/mantissa, with generic widths and bias.
- Uses a serial normaliser, guard/sticky rounding, zero, overflow and underflow handling, and valid/ready handshakes on both sides.
- Sits between the log-fraction generator and the result packer.

Parameters:
- INT_W, 8: integer-part width, two's complement, MSB is sign.
- FRAC_IN_W, 16: input fraction width.
- EXP_W, 8: output exponent width.
- MAN_W, 7: output mantissa width; hidden bit is not stored.
- BIAS, 127: exponent bias.
- Constraint: TOT = INT_W+FRAC_IN_W >= MAN_W+2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  block can accept an input
- int_i  in  INT_W  signed integer part
- frac_i  in  FRAC_IN_W  fractional part
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts the result
- sgn_o  out  1  result sign
- exp_o  out  EXP_W  biased exponent
- man_o  out  MAN_W  rounded mantissa
- zero_o  out  1  input was exactly zero
- ovf_o  out  1  exponent overflow, result saturated to infinity
- unf_o  out  1  exponent underflow, result flushed to zero

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready_o=1; internal mag, cnt, sgn cleared.
- Reset mid-operation: the in-flight word is discarded.
- Value interpretation: {int_i,frac_i} is a TOT-bit two's complement number scaled by 2^-FRAC_IN_W.
- in_ready_o=1 only in IDLE. A transfer occurs when in_valid_i & in_ready_o.
- States and transitions:
  - IDLE: on a transfer, capture sgn = input MSB and mag = |x| as TOT-bit unsigned. The most negative value gives mag = 2^(TOT-1). Set cnt = TOT-1. If mag==0, go to DONE with sgn=0, exp=0, man=0, zero=1. Otherwise go to NORM.
  - NORM: if mag[TOT-1]==1, go to ROUND. Otherwise shift mag left 1, decrement cnt, stay. One bit is examined per cycle.
  - ROUND: on entry the leading one is at mag[TOT-1] and cnt = p, its original position.
    - man = mag[TOT-2 -: MAN_W]; guard G = next lower bit; sticky S = OR of all remaining lower bits.
    - Round-up condition: G (default).
    - If man is all ones and a round-up occurs, man=0 and the exponent gets +1.
    - Exponent e = p - FRAC_IN_W + BIAS (+1 on carry), computed signed at EXP_W+2 bits.
    - If e >= 2^EXP_W-1: exp=all ones, man=0, ovf=1.
    - If e <= 0: exp=0, man=0, unf=1; sign is kept.
    - Register the outputs, then go to DONE.
  - DONE: out_valid_o=1. Outputs are held stable while out_ready_i=0. When out_ready_i=1, go to IDLE and drop out_valid_o the next cycle.
- Latency: with accept at edge t0 and k = TOT-1-p, out_valid_o rises at cycle t0+k+3. For zero input it rises at t0+1.
- No input is accepted in DONE, even in the cycle out_ready_i is high. Peak throughput is one word per k+4 cycles.
- Flags are mutually exclusive and valid only with out_valid_o.

Optional Feature:
- FX2F_RNE_EN defined: round-to-nearest-even. Round up iff G & (S | man[0]).
- Not defined: round-half-up. Round up iff G, matching the existing FLOG rounding.

Decomposition:
- flog_pkg gains:
  - FX2F_INT_W, FX2F_FRAC_W defaults.
  - The existing EXP_WIDTH, FRACT_WIDTH, BIAS, used as EXP_W/MAN_W/BIAS defaults.
  - The state typedef ss_FX2F {IDLE, NORM, ROUND, DONE}, as a 2-bit enum.
- Sub-module fx2f_round: combinational round/flag stage. Inputs: normalised mag, cnt. Outputs: exp, man and flags. The FX2F_RNE_EN switch lives there.

Test Plan (defaults: TOT=24, EXP_W=8, MAN_W=7, BIAS=127):
- Unit value: int=0x01, frac=0x0000 -> sgn0, exp 0x7F, man 0x00; out_valid 10 cycles after accept (k=7).
- Negative fraction: int=0xFF, frac=0x8000 (-0.5) -> sgn1, exp 0x7E, man 0x00.
- Tie rounding: int=0x01, frac=0x0100 -> man 0x01 without FX2F_RNE_EN; man 0x00 with it. Exp 0x7F in both cases.
- Mantissa carry: int=0x01, frac=0xFF00 -> exp 0x80, man 0x00 in both rounding modes.
- Extremes:
  - int=0x80, frac=0 -> sgn1, exp 0x86, man 0, out_valid 3 cycles after accept.
  - Zero input -> zero_o=1, all fields 0, out_valid 1 cycle after accept.
- Backpressure and reset:
  - Hold out_ready_i=0 for 5 cycles -> outputs stable and in_ready_o=0 throughout.
  - Assert rst during NORM -> next cycle IDLE, out_valid_o=0, in_ready_o=1.

Source files
------------

// File: rtl/flog_pkg.sv
// Shared definitions for the FLOG datapath.
//
// Holds the default widths and bias used by the fixed-point to float
// converter (fx2f_norm_round) and the converter's state type.
//   FX2F_INT_W / FX2F_FRAC_W : default integer / fraction widths of the input
//   EXP_WIDTH / FRACT_WIDTH  : exponent / stored-mantissa widths of the result
//   BIAS                     : exponent bias
//   ss_FX2F                  : IDLE -> NORM -> ROUND -> DONE (zero skips to DONE)
package flog_pkg;

    localparam int FX2F_INT_W  = 8;
    localparam int FX2F_FRAC_W = 16;

    localparam int EXP_WIDTH   = 8;
    localparam int FRACT_WIDTH = 7;
    localparam int BIAS        = 127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } ss_FX2F;

endpackage

// File: rtl/fx2f_round.sv
// Combinational round / exponent / flag stage of the fixed-point to float
// converter.
//
// Build option: define FX2F_RNE_EN for round-to-nearest-even; otherwise the
// stage rounds half-up (round up whenever the guard bit is set).
//
// Ports:
//   mag  in  TOT    normalised magnitude, leading one at mag[TOT-1]
//   cnt  in  CW     original bit position of that leading one
//   exp  out EXP_W  biased exponent (all ones on overflow, 0 on underflow)
//   man  out MAN_W  rounded mantissa without hidden bit
//   ovf  out 1      exponent overflow, result saturated to infinity
//   unf  out 1      exponent underflow, result flushed to zero
module fx2f_round
    import flog_pkg::*;
#(
    parameter int TOT       = FX2F_INT_W + FX2F_FRAC_W,
    parameter int CW        = $clog2(TOT),
    parameter int FRAC_IN_W = FX2F_FRAC_W,
    parameter int EXP_W     = EXP_WIDTH,
    parameter int MAN_W     = FRACT_WIDTH,
    parameter int BIAS      = flog_pkg::BIAS
) (
    input  logic [TOT-1:0]   mag,
    input  logic [CW-1:0]    cnt,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] man,
    output logic             ovf,
    output logic             unf
);

    localparam int GB = TOT - 2 - MAN_W;   // guard bit index
    localparam int EW = EXP_W + 2;         // signed exponent working width
    localparam logic signed [EW-1:0] E_OVF = EW'((1 << EXP_W) - 1);

    logic [MAN_W-1:0]     man_raw;
    logic [MAN_W:0]       man_inc;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic                 carry;
    logic [MAN_W-1:0]     man_rnd;
    logic signed [EW-1:0] e;

    assign man_raw = mag[TOT-2 -: MAN_W];
    assign guard   = mag[GB];

    // With TOT == MAN_W+2 there is nothing below the guard bit.
    generate
        if (GB > 0) begin : g_sticky
            assign sticky = |mag[GB-1:0];
        end else begin : g_no_sticky
            assign sticky = 1'b0;
        end
    endgenerate

`ifdef FX2F_RNE_EN
    assign round_up = guard & (sticky | man_raw[0]);
`else
    assign round_up = guard;
`endif

    // Rounding an all-ones mantissa wraps it to zero and bumps the exponent.
    assign man_inc = {1'b0, man_raw} + (MAN_W + 1)'(1);
    assign carry   = round_up & man_inc[MAN_W];
    assign man_rnd = round_up ? man_inc[MAN_W-1:0] : man_raw;

    assign e = EW'(int'(cnt) - FRAC_IN_W + BIAS + int'(carry));

    always_comb begin
        exp = e[EXP_W-1:0];
        man = man_rnd;
        ovf = 1'b0;
        unf = 1'b0;
        if (e >= E_OVF) begin
            exp = '1;
            man = '0;
            ovf = 1'b1;
        end else if (e[EW-1] || (e == '0)) begin
            exp = '0;
            man = '0;
            unf = 1'b1;
        end
    end

    // Hidden bit and high exponent bits are implied by construction.
    logic unused_bits;
    assign unused_bits = ^{mag[TOT-1], sticky, e[EW-1:EXP_W]};

endmodule

// File: rtl/fx2f_norm_round.sv
// Signed fixed-point to float converter for the FLOG datapath.
//
// {int_i, frac_i} is a two's complement value scaled by 2^-FRAC_IN_W. The
// magnitude is normalised one bit per cycle, then rounded and packed into
// sign / biased exponent / mantissa (hidden bit not stored).
// Build option: FX2F_RNE_EN selects round-to-nearest-even (see fx2f_round).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid_i    input word valid       in_ready_o   high only when idle
//   int_i         signed integer part    frac_i       fractional part
//   out_valid_o   result valid           out_ready_i  downstream accepts
//   sgn_o/exp_o/man_o                    result fields
//   zero_o/ovf_o/unf_o                   mutually exclusive flags
module fx2f_norm_round
    import flog_pkg::*;
#(
    parameter int INT_W     = FX2F_INT_W,
    parameter int FRAC_IN_W = FX2F_FRAC_W,
    parameter int EXP_W     = EXP_WIDTH,
    parameter int MAN_W     = FRACT_WIDTH,
    parameter int BIAS      = flog_pkg::BIAS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [INT_W-1:0]     int_i,
    input  logic [FRAC_IN_W-1:0] frac_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 sgn_o,
    output logic [EXP_W-1:0]     exp_o,
    output logic [MAN_W-1:0]     man_o,
    output logic                 zero_o,
    output logic                 ovf_o,
    output logic                 unf_o
);

    // TOT must be at least MAN_W+2 (hidden bit, mantissa, guard).
    localparam int TOT = INT_W + FRAC_IN_W;
    localparam int CW  = $clog2(TOT);

    ss_FX2F           state;
    logic [TOT-1:0]   mag;
    logic [CW-1:0]    cnt;
    logic             sgn;

    logic [TOT-1:0]   x_in;
    logic [TOT-1:0]   x_abs;
    logic [EXP_W-1:0] r_exp;
    logic [MAN_W-1:0] r_man;
    logic             r_ovf;
    logic             r_unf;

    assign x_in  = {int_i, frac_i};
    // The most negative input wraps to 2^(TOT-1), which is its true magnitude.
    assign x_abs = x_in[TOT-1] ? (~x_in + TOT'(1)) : x_in;

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    fx2f_round #(
        .TOT       (TOT),
        .CW        (CW),
        .FRAC_IN_W (FRAC_IN_W),
        .EXP_W     (EXP_W),
        .MAN_W     (MAN_W),
        .BIAS      (BIAS)
    ) u_round (
        .mag (mag),
        .cnt (cnt),
        .exp (r_exp),
        .man (r_man),
        .ovf (r_ovf),
        .unf (r_unf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mag    <= '0;
            cnt    <= '0;
            sgn    <= 1'b0;
            sgn_o  <= 1'b0;
            exp_o  <= '0;
            man_o  <= '0;
            zero_o <= 1'b0;
            ovf_o  <= 1'b0;
            unf_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        sgn <= x_in[TOT-1];
                        mag <= x_abs;
                        cnt <= CW'(TOT - 1);
                        if (x_abs == '0) begin
                            sgn_o  <= 1'b0;
                            exp_o  <= '0;
                            man_o  <= '0;
                            zero_o <= 1'b1;
                            ovf_o  <= 1'b0;
                            unf_o  <= 1'b0;
                            state  <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[TOT-1]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        cnt <= cnt - CW'(1);
                    end
                end
                ROUND: begin
                    sgn_o  <= sgn;
                    exp_o  <= r_exp;
                    man_o  <= r_man;
                    zero_o <= 1'b0;
                    ovf_o  <= r_ovf;
                    unf_o  <= r_unf;
                    state  <= DONE;
                end
                DONE: begin
                    if (out_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
